multi_cycle_washer: RTL and testbench
=====================================

MULTI_CYCLE_WASHER -- requirements
Module: multi_cycle_washer

Interface
REQ-001 SHALL have parameter TIMER_W, default 8, width of the internal phase timer.
REQ-002 SHALL have parameter SOAK_TICKS, default 20, minimum soak phase length in cycles.
REQ-003 SHALL have parameter WASH_TICKS, default 40, wash phase length in cycles.
REQ-004 SHALL have parameter RINSE_TICKS, default 30, length of each rinse agitation phase in cycles.
REQ-005 SHALL have parameter SPIN_TICKS, default 25, spin phase length in cycles.
REQ-006 SHALL have parameter RINSE_COUNT, default 2, number of rinse passes, legal range 0..7.
REQ-007 SHALL have parameter LEVEL_LIMIT, default 200, maximum cycles allowed in any fill or drain phase.
REQ-008 SHALL have port clk, input, 1 bit, single system clock; all state changes on its rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-010 SHALL have ports start, door, fill, soap_add, drain, each input, 1 bit: run request, door closed (1), tub full sensor, detergent present, tub empty sensor.
REQ-011 SHALL have ports lock, fill_valve, drain_valve, motor, soak, wash, rinse, done, fault, each output, 1 bit.
REQ-012 SHALL have port state_o, output, 4 bits, current state encoding for debug.

Function
REQ-013 States SHALL be IDLE, FILL, SOAK, WASH, DRAIN, RFILL, RINSE, SPIN, DONE, FAULT; all outputs Moore-decoded from the registered state.
REQ-014 IDLE -> FILL when start=1 and door=1; start while door=0 is ignored.
REQ-015 FILL -> SOAK when fill=1; RFILL -> RINSE when fill=1.
REQ-016 SOAK -> WASH when timer has reached SOAK_TICKS-1 and soap_add=1; without soap_add, timer saturates and SOAK holds.
REQ-017 WASH -> DRAIN after exactly WASH_TICKS cycles in WASH; RINSE -> DRAIN after exactly RINSE_TICKS cycles in RINSE.
REQ-018 DRAIN on drain=1: -> RFILL if rinse counter < RINSE_COUNT, else -> SPIN; rinse counter increments on each RINSE entry, clears in IDLE.
REQ-019 RINSE_COUNT=0: first DRAIN goes directly to SPIN.
REQ-020 SPIN -> DONE after exactly SPIN_TICKS cycles; DONE -> IDLE when start=0.
REQ-021 Timer SHALL clear to 0 on every state entry and increment each cycle, saturating at all-ones of TIMER_W.
REQ-022 FILL, RFILL or DRAIN lasting LEVEL_LIMIT cycles without its exit condition SHALL go to FAULT.
REQ-023 door=0 in any state other than IDLE, DONE or FAULT SHALL go to FAULT next cycle, with priority over all other transitions.
REQ-024 FAULT SHALL be exited only by reset.
REQ-025 Output decode: lock=1 in FILL..SPIN; fill_valve in FILL/RFILL; drain_valve in DRAIN/SPIN; motor in WASH/RINSE/SPIN; soak in SOAK; wash in WASH; rinse in RINSE; done in DONE; fault in FAULT; all else 0.
REQ-026 FAULT SHALL drive motor=0, fill_valve=0, drain_valve=1, lock=0.
REQ-027 Each transition SHALL take effect one clock after its condition is sampled.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, clear timer and rinse counter, and drive all outputs to 0, state_o to the IDLE code.
REQ-029 Reset asserted mid-cycle in any state SHALL abort the run with no output glitch beyond the asynchronous clear.

Verification
REQ-030 Params SOAK=4, WASH=6, RINSE=3, SPIN=5, RINSE_COUNT=2: full run -> sequence FILL,SOAK(4),WASH(6),DRAIN,RFILL,RINSE(3),DRAIN,RFILL,RINSE(3),DRAIN,SPIN(5),DONE; done=1, lock=0.
REQ-031 RINSE_COUNT=0 -> DRAIN goes straight to SPIN; rinse never asserts.
REQ-032 soap_add held 0 for 10 cycles in SOAK -> soak stays 1, no WASH until soap_add=1, then WASH next cycle.
REQ-033 LEVEL_LIMIT=10, fill held 0 -> FAULT after 10 cycles in FILL, fault=1, drain_valve=1, motor=0.
REQ-034 door=0 during WASH -> FAULT next clock; start toggling afterwards has no effect until rst_n pulse.
REQ-035 rst_n low during SPIN -> immediate IDLE, all outputs 0; start with door=1 afterwards begins a fresh run with rinse counter 0.

Source files
------------

// File: rtl/multi_cycle_washer.sv
// Washing-machine sequencer: fill, soak, wash, drain/rinse passes, spin.
// A door opening mid-run, or a fill or drain that times out, latches FAULT until reset.
module multi_cycle_washer #(
  parameter int TIMER_W     = 8,
  parameter int SOAK_TICKS  = 20,
  parameter int WASH_TICKS  = 40,
  parameter int RINSE_TICKS = 30,
  parameter int SPIN_TICKS  = 25,
  parameter int RINSE_COUNT = 2,
  parameter int LEVEL_LIMIT = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       door,
  input  logic       fill,
  input  logic       soap_add,
  input  logic       drain,
  output logic       lock,
  output logic       fill_valve,
  output logic       drain_valve,
  output logic       motor,
  output logic       soak,
  output logic       wash,
  output logic       rinse,
  output logic       done,
  output logic       fault,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    FILL  = 4'd1,
    SOAK  = 4'd2,
    WASH  = 4'd3,
    DRAIN = 4'd4,
    RFILL = 4'd5,
    RINSE = 4'd6,
    SPIN  = 4'd7,
    DONE  = 4'd8,
    FAULT = 4'd9
  } state_t;

  // Timer value on the last cycle of each phase.
  localparam logic [TIMER_W-1:0] SOAK_LAST  = TIMER_W'(SOAK_TICKS - 1);
  localparam logic [TIMER_W-1:0] WASH_LAST  = TIMER_W'(WASH_TICKS - 1);
  localparam logic [TIMER_W-1:0] RINSE_LAST = TIMER_W'(RINSE_TICKS - 1);
  localparam logic [TIMER_W-1:0] SPIN_LAST  = TIMER_W'(SPIN_TICKS - 1);
  localparam logic [TIMER_W-1:0] LEVEL_LAST = TIMER_W'(LEVEL_LIMIT - 1);
  localparam logic [2:0]         RINSE_MAX  = 3'(RINSE_COUNT);

  state_t             state;
  state_t             state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         rinse_cnt;
  logic               running;

  assign running = (state != IDLE) && (state != DONE) && (state != FAULT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start && door) state_nxt = FILL;
      FILL: begin
        if (fill)                     state_nxt = SOAK;
        else if (timer >= LEVEL_LAST) state_nxt = FAULT;
      end
      SOAK:  if (timer >= SOAK_LAST && soap_add) state_nxt = WASH;
      WASH:  if (timer == WASH_LAST) state_nxt = DRAIN;
      DRAIN: begin
        if (drain)                    state_nxt = (rinse_cnt < RINSE_MAX) ? RFILL : SPIN;
        else if (timer >= LEVEL_LAST) state_nxt = FAULT;
      end
      RFILL: begin
        if (fill)                     state_nxt = RINSE;
        else if (timer >= LEVEL_LAST) state_nxt = FAULT;
      end
      RINSE: if (timer == RINSE_LAST) state_nxt = DRAIN;
      SPIN:  if (timer == SPIN_LAST) state_nxt = DONE;
      DONE:  if (!start) state_nxt = IDLE;
      FAULT: state_nxt = FAULT;
      default: state_nxt = FAULT;
    endcase
    // An open door during a run overrides every other transition.
    if (running && !door) state_nxt = FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      rinse_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + TIMER_W'(1);
      if (state == IDLE)
        rinse_cnt <= '0;
      else if (state_nxt == RINSE && state != RINSE)
        rinse_cnt <= rinse_cnt + 3'd1;
    end
  end

  always_comb begin
    lock        = 1'b0;
    fill_valve  = 1'b0;
    drain_valve = 1'b0;
    motor       = 1'b0;
    soak        = 1'b0;
    wash        = 1'b0;
    rinse       = 1'b0;
    done        = 1'b0;
    fault       = 1'b0;
    case (state)
      FILL:  begin lock = 1'b1; fill_valve = 1'b1; end
      SOAK:  begin lock = 1'b1; soak = 1'b1; end
      WASH:  begin lock = 1'b1; motor = 1'b1; wash = 1'b1; end
      DRAIN: begin lock = 1'b1; drain_valve = 1'b1; end
      RFILL: begin lock = 1'b1; fill_valve = 1'b1; end
      RINSE: begin lock = 1'b1; motor = 1'b1; rinse = 1'b1; end
      SPIN:  begin lock = 1'b1; drain_valve = 1'b1; motor = 1'b1; end
      DONE:  done = 1'b1;
      FAULT: begin drain_valve = 1'b1; fault = 1'b1; end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_multi_cycle_washer.sv
// Directed bench for multi_cycle_washer: a two-rinse instance and a no-rinse instance
// share stimulus; state and output sequences are compared against hand-written tables.
module tb_multi_cycle_washer;

  localparam logic [3:0] S_IDLE = 4'd0, S_FILL = 4'd1, S_SOAK = 4'd2, S_WASH = 4'd3,
                         S_DRAIN = 4'd4, S_RFILL = 4'd5, S_RINSE = 4'd6, S_SPIN = 4'd7,
                         S_DONE = 4'd8, S_FAULT = 4'd9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, door = 1'b1, fill = 1'b0, soap_add = 1'b0, drain = 1'b0;

  logic lock_a, fv_a, dv_a, motor_a, soak_a, wash_a, rinse_a, done_a, fault_a;
  logic lock_b, fv_b, dv_b, motor_b, soak_b, wash_b, rinse_b, done_b, fault_b;
  logic [3:0] state_a, state_b;
  logic [8:0] out_a, out_b;

  int total = 0;
  int bad = 0;
  int exp_a[$];
  int exp_b[$];
  bit rinse_seen = 1'b0;

  assign out_a = {lock_a, fv_a, dv_a, motor_a, soak_a, wash_a, rinse_a, done_a, fault_a};
  assign out_b = {lock_b, fv_b, dv_b, motor_b, soak_b, wash_b, rinse_b, done_b, fault_b};

  always #5 clk = ~clk;

  multi_cycle_washer #(
    .TIMER_W(8), .SOAK_TICKS(4), .WASH_TICKS(6), .RINSE_TICKS(3), .SPIN_TICKS(5),
    .RINSE_COUNT(2), .LEVEL_LIMIT(10)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .door(door), .fill(fill),
    .soap_add(soap_add), .drain(drain),
    .lock(lock_a), .fill_valve(fv_a), .drain_valve(dv_a), .motor(motor_a),
    .soak(soak_a), .wash(wash_a), .rinse(rinse_a), .done(done_a), .fault(fault_a),
    .state_o(state_a)
  );

  multi_cycle_washer #(
    .TIMER_W(8), .SOAK_TICKS(4), .WASH_TICKS(6), .RINSE_TICKS(3), .SPIN_TICKS(5),
    .RINSE_COUNT(0), .LEVEL_LIMIT(10)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .door(door), .fill(fill),
    .soap_add(soap_add), .drain(drain),
    .lock(lock_b), .fill_valve(fv_b), .drain_valve(dv_b), .motor(motor_b),
    .soak(soak_b), .wash(wash_b), .rinse(rinse_b), .done(done_b), .fault(fault_b),
    .state_o(state_b)
  );

  // Output bundle {lock,fill_valve,drain_valve,motor,soak,wash,rinse,done,fault} per state.
  function automatic logic [8:0] exp_out(input int s);
    case (s)
      1:       return 9'b110000000;
      2:       return 9'b100010000;
      3:       return 9'b100101000;
      4:       return 9'b101000000;
      5:       return 9'b110000000;
      6:       return 9'b100100100;
      7:       return 9'b101100000;
      8:       return 9'b000000010;
      9:       return 9'b001000001;
      default: return 9'b000000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic build(input int st[], input int n[], output int q[$]);
    q = {};
    for (int k = 0; k < st.size(); k++)
      for (int j = 0; j < n[k]; j++) q.push_back(st[k]);
  endtask

  // Start pulse, then n clocks with the state and outputs checked after each edge.
  task automatic run_full(input int n, input bit chk_b);
    int eb;
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0) start = 1'b0;
      check($sformatf("seq_a[%0d]", i), 32'(state_a), 32'(exp_a[i]));
      check($sformatf("out_a[%0d]", i), 32'(out_a), 32'(exp_out(exp_a[i])));
      if (chk_b) begin
        eb = (i < exp_b.size()) ? exp_b[i] : 0;
        check($sformatf("seq_b[%0d]", i), 32'(state_b), 32'(eb));
        if (rinse_b) rinse_seen = 1'b1;
      end
    end
  endtask

  initial begin
    build('{1, 2, 3, 4, 5, 6, 4, 5, 6, 4, 7, 8, 0},
          '{1, 4, 6, 1, 1, 3, 1, 1, 3, 1, 5, 1, 1}, exp_a);
    build('{1, 2, 3, 4, 7, 8, 0}, '{1, 4, 6, 1, 5, 1, 1}, exp_b);

    #12;
    check("reset_state_a", 32'(state_a), 32'(S_IDLE));
    check("reset_out_a", 32'(out_a), 32'd0);
    check("reset_state_b", 32'(state_b), 32'(S_IDLE));
    rst_n = 1'b1;

    // Full run with sensors satisfied immediately.
    fill = 1'b1; drain = 1'b1; soap_add = 1'b1; door = 1'b1;
    step();
    run_full(29, 1'b1);
    check("no_rinse_b", 32'(rinse_seen), 32'd0);

    // Start with the door open is ignored.
    door = 1'b0; start = 1'b1;
    step(); step();
    check("door_open_start", 32'(state_a), 32'(S_IDLE));
    start = 1'b0; door = 1'b1;
    step();

    // Soak holds without detergent, then goes to wash the next cycle.
    soap_add = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check("soap_fill", 32'(state_a), 32'(S_FILL));
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("soap_hold[%0d]", i), 32'(state_a), 32'(S_SOAK));
      check($sformatf("soak_out[%0d]", i), 32'(soak_a), 32'd1);
    end
    soap_add = 1'b1;
    step();
    check("soap_wash", 32'(state_a), 32'(S_WASH));
    step(); step();

    // Door opened during wash: fault next clock, sticky until reset.
    door = 1'b0;
    step();
    check("door_fault", 32'(state_a), 32'(S_FAULT));
    check("door_fault_out", 32'(out_a), 32'(9'b001000001));
    door = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      step();
      check($sformatf("fault_sticky[%0d]", i), 32'(state_a), 32'(S_FAULT));
    end
    start = 1'b0;
    pulse_reset();
    check("fault_reset", 32'(state_a), 32'(S_IDLE));
    check("fault_reset_out", 32'(out_a), 32'd0);
    step();

    // Fill never reported: fault after LEVEL_LIMIT cycles in FILL.
    fill = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("fill_last", 32'(state_a), 32'(S_FILL));
    step();
    check("fill_timeout", 32'(state_a), 32'(S_FAULT));
    check("fill_timeout_out", 32'(out_a), 32'(9'b001000001));
    pulse_reset();
    step();

    // Reset asserted mid-cycle during spin, then a fresh two-rinse run.
    fill = 1'b1; drain = 1'b1; soap_add = 1'b1;
    run_full(23, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("spin_rst_state", 32'(state_a), 32'(S_IDLE));
    check("spin_rst_out", 32'(out_a), 32'd0);
    #2;
    rst_n = 1'b1;
    run_full(29, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
